// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// ALU operand forwarding select for one Execute-stage source register.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_rd_m,
    input  logic       i_reg_write_w,
    input  logic [4:0] i_rd_w,
    output logic [1:0] o_forward
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs);
    assign w_hit_w = i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs);

    // Memory stage holds the youngest result, so it wins over Writeback.
    always_comb begin
        o_forward = FWD_RF;
        if (w_hit_m) begin
            o_forward = FWD_M;
        end else if (w_hit_w) begin
            o_forward = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: forwarding, load-use/branch/memory-wait stalls and flushes,
// memory-wait timeout detection and saturating performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             RegWriteM,
    input  logic [4:0]       RdM,
    input  logic             RegWriteW,
    input  logic [4:0]       RdW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             CntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic              w_timeout_hit;
    logic              w_mem_stall;
    logic              w_lw_stall;

    forward_unit u_fwd_a (
        .i_rs          (Rs1E),
        .i_reg_write_m (RegWriteM),
        .i_rd_m        (RdM),
        .i_reg_write_w (RegWriteW),
        .i_rd_w        (RdW),
        .o_forward     (ForwardAE)
    );

    forward_unit u_fwd_b (
        .i_rs          (Rs2E),
        .i_reg_write_m (RegWriteM),
        .i_rd_m        (RdM),
        .i_reg_write_w (RegWriteW),
        .i_rd_w        (RdW),
        .o_forward     (ForwardBE)
    );

    assign w_lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        w_mem_stall   = 1'b0;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushW        = 1'b0;

        case (r_state)
            RUN: begin
                w_mem_stall = MemReqM && !MemReadyM;
                if (MemReqM && !MemReadyM) begin
                    w_state_next = MEMWAIT;
                end
            end
            MEMWAIT: begin
                w_mem_stall = !MemReadyM;
                if (MemReadyM) begin
                    w_state_next = RUN;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next  = RUN;
                    w_timeout_hit = 1'b1;
                end
            end
            default: w_state_next = RUN;
        endcase

        // A taken branch is not flushed during a memory stall; the frozen Execute stage re-presents it.
        if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if ((r_state == MEMWAIT) && (w_state_next == MEMWAIT)) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else if (CntClr) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (StallF && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (FlushD && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign MemTimeout  = r_timeout;
    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;

endmodule
